// File: rtl/pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// pc_fetch_ctrl
//
// Program-counter register and instruction-fetch sequencer.
//   - Holds the PC and drives it to the branch-target adder (pc_d).
//   - Issues one fetch at a time to instruction memory over a req/ack
//     handshake. The request and its address are held until the ack.
//   - Presents each fetched word to decode over a valid/ready handshake.
//   - Accepts redirects at any time. A fetch still in flight when a redirect
//     arrives completes normally, but its data is discarded.
//
// Optional feature, enabled by defining BRANCH_ALIGN_CHECK_EN:
//   A redirect whose target has bits [1:0] != 0 sets the sticky fault flag and
//   leaves the PC unchanged. The block then parks in FAULT once no request is
//   outstanding, and only reset releases it.
//   Without the macro, fault is always 0 and targets have bits [1:0] cleared.
//
// Ports:
//   clk              system clock, rising edge
//   rst_n            asynchronous active-low reset
//   stall            blocks new fetch launch and decode accept
//   redirect_valid   one-cycle pulse: load redirect_target into the PC
//   redirect_target  branch/jump target; only bits [PC_W-1:0] are used
//   pc_d             current PC register
//   imem_req         fetch request
//   imem_addr        fetch address, stable while imem_req=1
//   imem_ack         fetch completion; imem_rdata is valid in the same cycle
//   imem_rdata       fetched word
//   instr_valid      instr/instr_pc valid toward decode
//   instr            fetched instruction
//   instr_pc         address of instr
//   instr_ready      decode accepts when instr_valid & instr_ready & !stall
//   fault            sticky misaligned-target flag
// -----------------------------------------------------------------------------
module pc_fetch_ctrl #(
    parameter int              PC_W     = 10,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [31:0]     redirect_target,
    output logic [PC_W-1:0] pc_d,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [PC_W-1:0] instr_pc,
    input  logic            instr_ready,
    output logic            fault
);

`ifdef BRANCH_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t          state_q;
    logic [PC_W-1:0] pc_q;
    logic            started_q;     // low for the first cycle after reset
    logic            pend_q;        // redirect captured while a fetch is in flight
    logic [PC_W-1:0] pend_tgt_q;
    logic            imem_req_q;
    logic [PC_W-1:0] imem_addr_q;
    logic            instr_valid_q;
    logic [31:0]     instr_q;
    logic [PC_W-1:0] instr_pc_q;
    logic            fault_q;

    // Instructions are word aligned. The low two bits are cleared here, so a
    // loaded target is always a word address. With the alignment check enabled,
    // misaligned targets are rejected before they are loaded.
    logic [PC_W-1:0] tgt;
    logic            misaligned;
    logic            unused_target_bits;

    assign tgt                = {redirect_target[PC_W-1:2], 2'b00};
    assign misaligned         = ALIGN_CHECK && (redirect_target[1:0] != 2'b00);
    assign unused_target_bits = ^{redirect_target[31:PC_W], redirect_target[1:0]};

    // NOTE: every register in this block is assigned with <=. All state
    // updates then see the values from before the clock edge, no matter
    // in which order the statements appear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            started_q     <= 1'b0;
            pend_q        <= 1'b0;
            pend_tgt_q    <= '0;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= '0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            fault_q       <= 1'b0;
        end else begin
            started_q <= 1'b1;
            if (redirect_valid && misaligned) begin
                fault_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    // A redirect takes priority over launching a fetch. The
                    // next fetch then uses the new PC.
                    if (redirect_valid) begin
                        if (misaligned) begin
                            state_q <= ST_FAULT;
                        end else begin
                            pc_q <= tgt;
                        end
                    end else if (started_q && !stall) begin
                        state_q     <= ST_REQ;
                        imem_req_q  <= 1'b1;
                        imem_addr_q <= pc_q;
                    end
                end

                ST_REQ: begin
                    if (imem_ack) begin
                        imem_req_q <= 1'b0;
                        pend_q     <= 1'b0;
                        if (fault_q || (redirect_valid && misaligned)) begin
                            state_q <= ST_FAULT;
                        end else if (redirect_valid) begin
                            // A redirect in the ack cycle is the newest one
                            // and replaces any pending target.
                            pc_q    <= tgt;
                            state_q <= ST_IDLE;
                        end else if (pend_q) begin
                            pc_q    <= pend_tgt_q;
                            state_q <= ST_IDLE;
                        end else begin
                            instr_q       <= imem_rdata;
                            instr_pc_q    <= pc_q;
                            instr_valid_q <= 1'b1;
                            pc_q          <= pc_q + PC_W'(4);
                            state_q       <= ST_HOLD;
                        end
                    end else if (redirect_valid && !misaligned) begin
                        // The request stays up. Only the target is recorded,
                        // and a later redirect overwrites it.
                        pend_q     <= 1'b1;
                        pend_tgt_q <= tgt;
                    end
                end

                ST_HOLD: begin
                    // A redirect squashes the held instruction, even when
                    // decode accepts it in the same cycle.
                    if (redirect_valid) begin
                        instr_valid_q <= 1'b0;
                        if (misaligned) begin
                            state_q <= ST_FAULT;
                        end else begin
                            pc_q    <= tgt;
                            state_q <= ST_IDLE;
                        end
                    end else if (instr_ready && !stall) begin
                        instr_valid_q <= 1'b0;
                        state_q       <= ST_IDLE;
                    end
                end

                ST_FAULT: begin
                    imem_req_q    <= 1'b0;
                    instr_valid_q <= 1'b0;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign pc_d        = pc_q;
    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_ctrl
//
// Directed testbench for pc_fetch_ctrl with PC_W=10 and RESET_PC=0.
// The bench acts as instruction memory and decode, cycle by cycle. It
// drives inputs and samples outputs 1 time unit after each rising edge.
// The expected values are worked out by hand from the fetch/redirect rules.
// -----------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

    localparam int PC_W = 10;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            stall;
    logic            redirect_valid;
    logic [31:0]     redirect_target;
    logic [PC_W-1:0] pc_d;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic            instr_valid;
    logic [31:0]     instr;
    logic [PC_W-1:0] instr_pc;
    logic            instr_ready;
    logic            fault;

    int checks   = 0;
    int failures = 0;

    pc_fetch_ctrl #(
        .PC_W     (PC_W),
        .RESET_PC ('0)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .pc_d            (pc_d),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_ready     (instr_ready),
        .fault           (fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
            $error("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        imem_ack        = 1'b0;
        imem_rdata      = '0;
        instr_ready     = 1'b1;

        // ---- reset state ----
        tick(); tick(); tick();
        check("rst_imem_req",    32'(imem_req),    32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr",       instr,            32'd0);
        check("rst_instr_pc",    32'(instr_pc),    32'd0);
        check("rst_pc_d",        32'(pc_d),        32'd0);
        check("rst_fault",       32'(fault),       32'd0);
        rst_n = 1'b1;

        // ---- sequential fetch 0x000, 0x004, 0x008 ----
        tick();  // first edge after release: still idle
        check("edge1_req_low", 32'(imem_req), 32'd0);
        tick();  // second edge: request rises
        check("edge2_req_high", 32'(imem_req),  32'd1);
        check("addr_000",       32'(imem_addr), 32'h000);
        imem_ack = 1'b1; imem_rdata = 32'hA000_0000;
        tick();
        imem_ack = 1'b0;
        check("f0_valid",    32'(instr_valid), 32'd1);
        check("f0_instr",    instr,            32'hA000_0000);
        check("f0_instr_pc", 32'(instr_pc),    32'h000);
        check("f0_req_drop", 32'(imem_req),    32'd0);
        check("f0_pc_d",     32'(pc_d),        32'h004);
        tick();  // accepted by decode
        check("f0_accepted", 32'(instr_valid), 32'd0);
        tick();
        check("addr_004", 32'(imem_addr), 32'h004);
        check("req_004",  32'(imem_req),  32'd1);
        imem_ack = 1'b1; imem_rdata = 32'hA000_0001;
        tick();
        imem_ack = 1'b0;
        check("f1_instr_pc", 32'(instr_pc), 32'h004);
        check("f1_pc_d",     32'(pc_d),     32'h008);
        tick();
        tick();
        check("addr_008", 32'(imem_addr), 32'h008);

        // ---- redirect while a fetch is in flight; late ack is discarded ----
        redirect_valid = 1'b1; redirect_target = 32'h0000_0120;
        tick();
        redirect_valid = 1'b0;
        check("inflight_req_held",  32'(imem_req),  32'd1);
        check("inflight_addr_held", 32'(imem_addr), 32'h008);
        check("inflight_pc_same",   32'(pc_d),      32'h008);
        tick(); tick();
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        check("stale_no_valid", 32'(instr_valid), 32'd0);
        check("stale_req_drop", 32'(imem_req),    32'd0);
        check("redir_pc_120",   32'(pc_d),        32'h120);
        tick();
        check("addr_120",       32'(imem_addr),   32'h120);
        check("addr_120_novld", 32'(instr_valid), 32'd0);

        // ---- hold with decode not ready, then redirect beats accept ----
        instr_ready = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'h2222_2222;
        tick();
        imem_ack = 1'b0;
        check("hold_pc_124", 32'(pc_d), 32'h124);
        tick(); tick(); tick(); tick(); tick();
        check("hold_valid_kept", 32'(instr_valid), 32'd1);
        check("hold_instr_kept", instr,            32'h2222_2222);
        check("hold_ipc_kept",   32'(instr_pc),    32'h120);
        check("hold_no_req",     32'(imem_req),    32'd0);
        instr_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0000_0040;
        tick();
        redirect_valid = 1'b0;
        check("squash_valid_drop", 32'(instr_valid), 32'd0);
        check("squash_pc_040",     32'(pc_d),        32'h040);
        tick();
        check("addr_040", 32'(imem_addr), 32'h040);
        imem_ack = 1'b1; imem_rdata = 32'h3333_3333;
        tick();
        imem_ack = 1'b0;
        check("f040_instr_pc", 32'(instr_pc), 32'h040);
        tick();  // accepted

        // ---- wrap-around and upper target bits ignored ----
        redirect_valid = 1'b1; redirect_target = 32'h0000_03FC;
        tick();
        redirect_valid = 1'b0;
        check("idle_redir_pc_3fc", 32'(pc_d),     32'h3FC);
        check("idle_redir_no_req", 32'(imem_req), 32'd0);
        tick();
        check("addr_3fc", 32'(imem_addr), 32'h3FC);
        imem_ack = 1'b1; imem_rdata = 32'h4444_4444;
        tick();
        imem_ack = 1'b0;
        check("wrap_pc_000", 32'(pc_d), 32'h000);
        tick();
        tick();
        check("addr_wrap_000", 32'(imem_addr), 32'h000);
        imem_ack = 1'b1; imem_rdata = 32'h5555_5555;
        tick();
        imem_ack = 1'b0;
        tick();  // accepted, back to idle
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_F200;
        tick();
        redirect_valid = 1'b0;
        check("trunc_pc_200", 32'(pc_d), 32'h200);

        // ---- stall in idle, then stall during an in-flight request ----
        stall = 1'b1;
        tick(); tick(); tick(); tick();
        check("stall_idle_no_req", 32'(imem_req), 32'd0);
        stall = 1'b0;
        tick();
        check("unstall_req",  32'(imem_req),  32'd1);
        check("unstall_addr", 32'(imem_addr), 32'h200);
        stall = 1'b1;
        imem_ack = 1'b1; imem_rdata = 32'h6666_6666;
        tick();
        imem_ack = 1'b0;
        check("stall_ack_valid", 32'(instr_valid), 32'd1);
        check("stall_ack_instr", instr,            32'h6666_6666);
        tick(); tick();
        check("stall_hold_valid", 32'(instr_valid), 32'd1);
        check("stall_hold_noreq", 32'(imem_req),    32'd0);
        stall = 1'b0;
        tick();
        check("unstall_accept", 32'(instr_valid), 32'd0);
        tick();
        check("addr_204", 32'(imem_addr), 32'h204);
        imem_ack = 1'b1; imem_rdata = 32'h7777_7777;
        tick();
        imem_ack = 1'b0;
        tick();  // accepted, back to idle

        // ---- misaligned redirect ----
        redirect_valid = 1'b1; redirect_target = 32'h0000_0102;
        tick();
        redirect_valid = 1'b0;
`ifdef BRANCH_ALIGN_CHECK_EN
        check("mis_fault_set", 32'(fault), 32'd1);
        check("mis_pc_kept",   32'(pc_d),  32'h208);
        tick(); tick(); tick();
        check("fault_no_req",   32'(imem_req),    32'd0);
        check("fault_no_valid", 32'(instr_valid), 32'd0);
        check("fault_sticky",   32'(fault),       32'd1);
`else
        check("mis_no_fault", 32'(fault), 32'd0);
        check("mis_pc_100",   32'(pc_d),  32'h100);
        tick();
        check("addr_100", 32'(imem_addr), 32'h100);

        // ---- several redirects before the ack: the last one wins ----
        redirect_valid = 1'b1; redirect_target = 32'h0000_0080;
        tick();
        redirect_target = 32'h0000_00C0;
        tick();
        redirect_valid = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'h8888_8888;
        tick();
        imem_ack = 1'b0;
        check("last_wins_pc",    32'(pc_d),        32'h0C0);
        check("last_wins_novld", 32'(instr_valid), 32'd0);
        tick();
        check("addr_0c0", 32'(imem_addr), 32'h0C0);

        // ---- redirect in the ack cycle itself ----
        imem_ack = 1'b1; imem_rdata = 32'h9999_9999;
        redirect_valid = 1'b1; redirect_target = 32'h0000_0010;
        tick();
        imem_ack = 1'b0; redirect_valid = 1'b0;
        check("ackcyc_pc_010", 32'(pc_d),        32'h010);
        check("ackcyc_novld",  32'(instr_valid), 32'd0);
        tick();
        check("addr_010", 32'(imem_addr), 32'h010);
        check("end_fault_0", 32'(fault),  32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
